// File: rtl/pc_ras_unit_if.sv
// rtl/pc_ras_unit_if.sv - control/status bundle between the fetch PC unit and its steering logic
//
// Purpose: carries the redirect controls into pc_ras_unit and its registered
// PC / EPC / return-address-stack status back out.
// Signals:
//   keep, jump, call, ret, exc : redirect / stall controls (into the unit)
//   target                     : jump destination (into the unit)
//   pc, epc                    : current PC and PC captured at last exception
//   ras_count, ras_empty,
//   ras_full, ras_underflow    : return-address-stack status
// Modports: slave = the PC unit, master = whoever steers it.
interface pc_ras_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             keep;
  logic             jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] target;
  logic             exc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;
  logic [CW-1:0]    ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;

  modport slave (
    input  keep, jump, call, ret, target, exc,
    output pc, epc, ras_count, ras_empty, ras_full, ras_underflow
  );

  modport master (
    output keep, jump, call, ret, target, exc,
    input  pc, epc, ras_count, ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - fetch-stage program counter with circular return-address stack
//
// Purpose: holds the PC, advances it by INC, and redirects on jump, call,
// return and exception. Calls push the return address onto a circular RAS;
// returns pop it. Exceptions jump to EXC_VEC, capture EPC and flush the RAS.
// Ports:
//   clk : clock, all state changes on rising edge
//   rst : asynchronous active-high reset
//   bus : pc_ras_unit_if slave modport (controls in, registered status out)
module pc_ras_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      INC       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h8000_0180),
  parameter int unsigned      DEPTH     = 8
) (
  input  logic          clk,
  input  logic          rst,
  pc_ras_unit_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             empty_q, full_q;

  // Entry storage is deliberately left out of reset: only sp/count define
  // which entries are live, so stale contents are never observable.
  logic [WIDTH-1:0] ras_q [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    sp_dec;
  logic             push;

  assign pc_inc = pc_q + WIDTH'(INC);
  assign sp_dec = sp_q - PW'(1);

  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    sp_d        = sp_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    push        = 1'b0;

    if (bus.exc) begin
      pc_d    = EXC_VEC;
      epc_d   = pc_q;
      sp_d    = '0;
      count_d = '0;
    end else if (bus.keep) begin
      // full hold; underflow pulse is cleared by the default above
    end else if (bus.jump) begin
      pc_d = bus.target;
      if (bus.call) begin
        push = 1'b1;
        sp_d = sp_q + PW'(1);
        // Pushing on a full stack overwrites the oldest entry; count saturates.
        if (count_q != FULL_COUNT) begin
          count_d = count_q + CW'(1);
        end
      end
    end else if (bus.ret) begin
      if (count_q != '0) begin
        pc_d    = ras_q[sp_dec];
        sp_d    = sp_dec;
        count_d = count_q - CW'(1);
      end else begin
        pc_d        = pc_inc;
        underflow_d = 1'b1;
      end
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_VEC;
      epc_q       <= RESET_VEC;
      sp_q        <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      sp_q        <= sp_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == FULL_COUNT);
    end
  end

  // Gated by rst so a push racing an asynchronous reset is dropped too.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ras_q[sp_q] <= pc_inc;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.epc           = epc_q;
  assign bus.ras_count     = count_q;
  assign bus.ras_empty     = empty_q;
  assign bus.ras_full      = full_q;
  assign bus.ras_underflow = underflow_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// tb/tb_pc_ras_unit.sv - directed self-checking bench for pc_ras_unit
module tb_pc_ras_unit;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0000_0400;
  localparam logic [31:0] EVEC  = 32'h8000_0180;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pc_ras_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_ras_unit #(
    .WIDTH(WIDTH), .INC(4), .RESET_VEC(RVEC), .EXC_VEC(EVEC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic drive(input logic k, input logic j, input logic c,
                       input logic r, input logic [31:0] t, input logic e);
    bus.keep = k; bus.jump = j; bus.call = c; bus.ret = r; bus.target = t; bus.exc = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h404; exp_seq[1] = 32'h408; exp_seq[2] = 32'h40C;
    drive(0, 0, 0, 0, 32'h0, 0);
    tick(); tick();
    tests_run++; if (bus.pc !== RVEC) begin fails++; $display("FAIL rst_pc got %h exp %h", bus.pc, RVEC); end
    tests_run++; if (bus.epc !== RVEC) begin fails++; $display("FAIL rst_epc got %h exp %h", bus.epc, RVEC); end
    tests_run++; if (bus.ras_count !== 3'd0 || bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0 || bus.ras_underflow !== 1'b0) begin
      fails++; $display("FAIL rst_flags got cnt=%0d e=%b f=%b u=%b exp cnt=0 e=1 f=0 u=0", bus.ras_count, bus.ras_empty, bus.ras_full, bus.ras_underflow); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (bus.pc !== exp_seq[i]) begin fails++; $display("FAIL seq_%0d pc got %h exp %h", i, bus.pc, exp_seq[i]); end
    end
    drive(0, 1, 1, 0, 32'h500, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    tests_run++; if (bus.pc !== 32'h500 || bus.ras_count !== 3'd1) begin fails++; $display("FAIL pre_rst_call got pc=%h cnt=%0d exp pc=00000500 cnt=1", bus.pc, bus.ras_count); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (bus.pc !== RVEC) begin fails++; $display("FAIL async_rst_pc got %h exp %h", bus.pc, RVEC); end
    tests_run++; if (bus.ras_empty !== 1'b1 || bus.ras_count !== 3'd0) begin fails++; $display("FAIL async_rst_ras got e=%b cnt=%0d exp e=1 cnt=0", bus.ras_empty, bus.ras_count); end
    tick();
    rst = 1'b0;
    tests_run++; if (bus.pc !== RVEC) begin fails++; $display("FAIL rst_hold_pc got %h exp %h", bus.pc, RVEC); end
  endtask

  task automatic test_call_return();
    drive(0, 1, 0, 0, 32'h100, 0); tick();
    tests_run++; if (bus.pc !== 32'h100) begin fails++; $display("FAIL cr_jump pc got %h exp 00000100", bus.pc); end
    drive(0, 1, 1, 0, 32'h800, 0); tick();
    tests_run++; if (bus.pc !== 32'h800 || bus.ras_count !== 3'd1) begin fails++; $display("FAIL cr_call1 got pc=%h cnt=%0d exp pc=00000800 cnt=1", bus.pc, bus.ras_count); end
    drive(0, 0, 0, 0, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h804) begin fails++; $display("FAIL cr_seq pc got %h exp 00000804", bus.pc); end
    drive(0, 1, 1, 0, 32'hC00, 0); tick();
    tests_run++; if (bus.pc !== 32'hC00 || bus.ras_count !== 3'd2) begin fails++; $display("FAIL cr_call2 got pc=%h cnt=%0d exp pc=00000c00 cnt=2", bus.pc, bus.ras_count); end
    drive(0, 0, 0, 1, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h808 || bus.ras_count !== 3'd1) begin fails++; $display("FAIL cr_ret1 got pc=%h cnt=%0d exp pc=00000808 cnt=1", bus.pc, bus.ras_count); end
    tick();
    tests_run++; if (bus.pc !== 32'h104 || bus.ras_empty !== 1'b1) begin fails++; $display("FAIL cr_ret2 got pc=%h e=%b exp pc=00000104 e=1", bus.pc, bus.ras_empty); end
    drive(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic test_overflow_underflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24;
    drive(0, 1, 0, 0, 32'h10, 0); tick();
    // calls from 0x10..0x50: pushes 0x14 (later overwritten), 0x24, 0x34, 0x44, 0x54
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 32'h20 + 32'(i) * 32'h10, 0); tick();
    end
    tests_run++; if (bus.ras_full !== 1'b1 || bus.ras_count !== 3'd4 || bus.pc !== 32'h60) begin
      fails++; $display("FAIL ovf_full got f=%b cnt=%0d pc=%h exp f=1 cnt=4 pc=00000060", bus.ras_full, bus.ras_count, bus.pc); end
    drive(0, 0, 0, 1, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (bus.pc !== exp_ret[i]) begin fails++; $display("FAIL ovf_ret_%0d pc got %h exp %h", i, bus.pc, exp_ret[i]); end
    end
    tick();
    tests_run++; if (bus.pc !== 32'h28 || bus.ras_underflow !== 1'b1 || bus.ras_count !== 3'd0) begin
      fails++; $display("FAIL udf_pulse got pc=%h u=%b cnt=%0d exp pc=00000028 u=1 cnt=0", bus.pc, bus.ras_underflow, bus.ras_count); end
    drive(0, 0, 0, 0, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h2C || bus.ras_underflow !== 1'b0) begin
      fails++; $display("FAIL udf_clear got pc=%h u=%b exp pc=0000002c u=0", bus.pc, bus.ras_underflow); end
  endtask

  task automatic test_priority();
    drive(1, 1, 0, 0, 32'h999, 0); tick();
    tests_run++; if (bus.pc !== 32'h2C) begin fails++; $display("FAIL pri_keep_jump pc got %h exp 0000002c", bus.pc); end
    drive(0, 1, 1, 0, 32'h200, 0); tick();
    tests_run++; if (bus.pc !== 32'h200 || bus.ras_count !== 3'd1) begin fails++; $display("FAIL pri_setup got pc=%h cnt=%0d exp pc=00000200 cnt=1", bus.pc, bus.ras_count); end
    drive(1, 1, 1, 1, 32'h999, 1); tick();
    tests_run++; if (bus.pc !== EVEC || bus.epc !== 32'h200) begin fails++; $display("FAIL pri_exc got pc=%h epc=%h exp pc=%h epc=00000200", bus.pc, bus.epc, EVEC); end
    tests_run++; if (bus.ras_count !== 3'd0 || bus.ras_empty !== 1'b1) begin fails++; $display("FAIL pri_exc_flush got cnt=%0d e=%b exp cnt=0 e=1", bus.ras_count, bus.ras_empty); end
    drive(0, 1, 1, 0, 32'h300, 0); tick();
    drive(0, 1, 0, 1, 32'h700, 0); tick();
    tests_run++; if (bus.pc !== 32'h700 || bus.ras_count !== 3'd1) begin fails++; $display("FAIL pri_jump_ret got pc=%h cnt=%0d exp pc=00000700 cnt=1", bus.pc, bus.ras_count); end
    drive(0, 0, 0, 1, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h8000_0184 || bus.ras_count !== 3'd0) begin fails++; $display("FAIL pri_ret_after got pc=%h cnt=%0d exp pc=80000184 cnt=0", bus.pc, bus.ras_count); end
    drive(0, 0, 1, 0, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h8000_0188 || bus.ras_count !== 3'd0) begin fails++; $display("FAIL pri_call_only got pc=%h cnt=%0d exp pc=80000188 cnt=0", bus.pc, bus.ras_count); end
    drive(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 0, 32'hFFFF_FFFC, 0); tick();
    drive(0, 0, 0, 0, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL wrap_seq pc got %h exp 00000000", bus.pc); end
    drive(0, 1, 0, 0, 32'hFFFF_FFFC, 0); tick();
    drive(0, 1, 1, 0, 32'h1000, 0); tick();
    drive(0, 0, 0, 0, 32'h0, 0); tick();
    drive(0, 0, 0, 1, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h0 || bus.ras_count !== 3'd0) begin fails++; $display("FAIL wrap_ret got pc=%h cnt=%0d exp pc=00000000 cnt=0", bus.pc, bus.ras_count); end
    drive(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 1, 0, 32'h40, 0); tick();
    drive(1, 0, 0, 1, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (bus.pc !== 32'h40 || bus.ras_count !== 3'd1) begin fails++; $display("FAIL stall_%0d got pc=%h cnt=%0d exp pc=00000040 cnt=1", i, bus.pc, bus.ras_count); end
    end
    drive(0, 0, 0, 1, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h4 || bus.ras_count !== 3'd0) begin fails++; $display("FAIL stall_release got pc=%h cnt=%0d exp pc=00000004 cnt=0", bus.pc, bus.ras_count); end
    drive(0, 1, 1, 0, 32'h900, 0); tick();
    drive(0, 0, 0, 1, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h8 || bus.ras_empty !== 1'b1) begin fails++; $display("FAIL b2b_ret got pc=%h e=%b exp pc=00000008 e=1", bus.pc, bus.ras_empty); end
    drive(1, 0, 0, 1, 32'h0, 0); tick();
    tests_run++; if (bus.pc !== 32'h8 || bus.ras_underflow !== 1'b0) begin fails++; $display("FAIL keep_no_udf got pc=%h u=%b exp pc=00000008 u=0", bus.pc, bus.ras_underflow); end
    drive(0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 32'h0, 0);
    test_reset();
    test_call_return();
    test_overflow_underflow();
    test_priority();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/pc_ras_unit.md
# pc_ras_unit

Parametrised program-counter unit for the fetch stage: holds the PC, advances by a fixed increment, and redirects on jump, return and exception. Supersedes the plain PC register by adding a circular return-address stack (RAS) for call/return, an exception vector with captured EPC, and configurable width and reset vector. Sits at the front of the pipeline, driving the instruction-memory address, and is steered by the hazard unit (`keep`) and the branch/exception logic.

## Interface

Parameters:
- `WIDTH`, 32, PC/address width in bits
- `INC`, 4, sequential increment added to PC
- `RESET_VEC`, 0, PC value on reset
- `EXC_VEC`, 32'h8000_0180 (truncated/extended to WIDTH), exception handler address
- `DEPTH`, 8, RAS entries; power of two, ≥2

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `keep`  in  1  stall: hold PC and RAS (does not block `exc`)
- `jump`  in  1  redirect to `target`
- `call`  in  1  qualifies `jump` as a call: push return address
- `ret`  in  1  return: pop RAS and redirect to popped address
- `target`  in  WIDTH  jump destination
- `exc`  in  1  exception: redirect to `EXC_VEC`, capture EPC, flush RAS
- `pc`  out  WIDTH  current PC (registered)
- `epc`  out  WIDTH  PC at last exception (registered)
- `ras_count`  out  $clog2(DEPTH)+1  valid RAS entries
- `ras_empty`  out  1  `ras_count == 0`
- `ras_full`  out  1  `ras_count == DEPTH`
- `ras_underflow`  out  1  registered one-cycle pulse: `ret` taken on empty RAS

## Operation

Next-state priority per cycle (first match wins):
1. `exc`: pc←EXC_VEC; epc←pc; ras_count←0 (stack pointer reset to 0). Overrides `keep`, `jump`, `call`, `ret`.
2. `keep`: pc, epc, RAS hold; `ras_underflow`←0.
3. `jump & call`: pc←target; push (pc+INC) onto RAS.
4. `jump`: pc←target; RAS unchanged. `ret` with `jump` is ignored (no pop).
5. `ret`: if ras_count>0, pc←top entry, pop; else pc←pc+INC, `ras_underflow`←1.
6. otherwise: pc←pc+INC.
- `call` without `jump`: ignored.
- Arithmetic: pc+INC modulo 2^WIDTH (0xFFFF_FFFC+4 → 0x0000_0000 at WIDTH=32). `target` used unmodified; no alignment checks.
- RAS is circular: write pointer `sp` (log2 DEPTH bits) wraps modulo DEPTH. Push writes entry[sp], sp←sp+1, count←min(count+1, DEPTH). Pop reads entry[sp-1], sp←sp-1, count←count-1.
- Push when full: overwrites oldest entry, count stays DEPTH; no error flag.
- Entry storage is not cleared by reset or exception; only `sp`/count are reset. Contents of invalid entries are don't-care and must never be popped.
- `ras_underflow` is 0 every cycle it is not set by rule 5.

## Timing

- Reset (async assert, any time, including mid-push/pop): pc=RESET_VEC, epc=RESET_VEC, ras_count=0, sp=0, ras_empty=1, ras_full=0, ras_underflow=0. In-flight operation discarded.
- After reset deassert, first rising edge with no control input gives pc=RESET_VEC+INC.
- All redirects take effect on the edge where the control is sampled: 1-cycle latency, no bubbles generated internally.
- Popped value appears on `pc` the edge after `ret`; a `call` followed immediately by `ret` next cycle returns the just-pushed address (push/pop are back-to-back safe).
- `ras_count`, flags and `epc` update on the same edge as `pc`.
- All outputs purely registered; no combinational path from inputs to outputs.

## Test plan

- Reset/sequential: WIDTH=32, RESET_VEC=0x400; deassert rst, 3 idle cycles -> pc 0x404, 0x408, 0x40C; assert rst mid-run -> pc=0x400 immediately (async), ras_empty=1.
- Call/return nesting: pc=0x100, jump+call target=0x800 -> pc=0x800, ras_count=1; at 0x804 jump+call target=0xC00 -> ras_count=2; ret -> pc=0x808; ret -> pc=0x104, ras_empty=1.
- Overflow/underflow: DEPTH=4, 5 calls from 0x10,0x20,0x30,0x40,0x50 -> ras_full=1, count=4; 4 rets -> pc 0x54,0x44,0x34,0x24; 5th ret at pc=X -> pc=X+4, ras_underflow=1 for one cycle.
- Priority: keep=1 with jump -> pc holds; keep=1 with exc at pc=0x200 -> pc=EXC_VEC, epc=0x200, ras_count=0; jump+ret together -> pc=target, count unchanged.
- Wrap: pc=0xFFFF_FFFC, idle -> pc=0x0000_0000; call at 0xFFFF_FFFC -> pushed 0x0, later ret -> pc=0x0.
- Stall during stack ops: call, then keep=1 for 3 cycles with ret asserted -> no pop, count=1; release keep with ret -> pc=return address.
